pk_uart_tx: RTL and testbench

- Downstream consumer of the pack stage's byte stream (pk_data/pk_vld/pk_frm). Sits at the front end of the communication stage.
- Buffers packed bytes in a FIFO and serialises them as UART 8N1 onto the local RS-485 transmit line (tx_a_local path).
- Drives the transceiver driver-enable and receiver-disable with guard times around each frame.
- Reports FIFO occupancy, a busy flag and a saturating overflow count for the fx register block.

---
 rtl/pk_uart_tx.sv | 203 ++++++++++++++++++++
 tb/tb_pk_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pk_uart_tx.sv
// pk_uart_tx: byte FIFO feeding an 8N1 UART transmitter on the local RS-485 line.
// Drives the driver-enable/receiver-disable pair with guard bit times around each frame.
module pk_uart_tx #(
  parameter int DEPTH      = 64,
  parameter int BAUD_DIV   = 10,
  parameter int GUARD_PRE  = 2,
  parameter int GUARD_POST = 1
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic [7:0]               pk_data,
  input  logic                     pk_vld,
  input  logic                     pk_frm,
  output logic                     tx,
  output logic                     te,
  output logic                     re,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [7:0]               ovf_cnt,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C      = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO_C  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);
  localparam logic [15:0]   BAUD_LAST_C = 16'(BAUD_DIV - 1);
  localparam logic [15:0]   PRE_LAST_C  = 16'(GUARD_PRE - 1);
  localparam logic [15:0]   POST_LAST_C = 16'(GUARD_POST - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_POST  = 3'd6
  } state_t;

  state_t         state_r;
  logic [15:0]    baud_r;
  logic [15:0]    guard_r;
  logic [2:0]     bit_r;
  logic [7:0]     shift_r;
  logic           tx_r;
  logic           te_r;
  logic [7:0]     mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  cnt_r;
  logic [7:0]     ovf_r;

  logic           tick_s;
  logic           empty_s;
  logic           full_s;
  logic           wr_s;
  logic           pop_s;
  logic [7:0]     head_s;

  // Bit-boundary tick, FIFO status and the pop request that starts every character.
  always_comb begin
    tick_s  = (baud_r == BAUD_LAST_C);
    empty_s = (cnt_r == CNT_ZERO_C);
    full_s  = (cnt_r == FULL_C);
    wr_s    = pk_vld & ~full_s;
    head_s  = mem_r[rd_ptr_r];
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE:                   pop_s = ~empty_s && (GUARD_PRE == 0);
      ST_PRE:                    pop_s = tick_s && (guard_r == PRE_LAST_C);
      ST_STOP, ST_HOLD, ST_POST: pop_s = tick_s && ~empty_s;
      default:                   pop_s = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk_sys) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= pk_data;
    end
  end

  // FIFO pointers, occupancy and the saturating overflow counter.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= CNT_ZERO_C;
      ovf_r    <= 8'd0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      case ({wr_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE_C;
        2'b01:   cnt_r <= cnt_r - CNT_ONE_C;
        default: cnt_r <= cnt_r;
      endcase
      // Full is judged on the registered count, so a same-cycle pop never rescues a write.
      if (ovf_clr) begin
        ovf_r <= 8'd0;
      end else if (pk_vld && full_s && (ovf_r != 8'hFF)) begin
        ovf_r <= ovf_r + 8'd1;
      end
    end
  end

  // Transmit state machine with registered line and enable outputs.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      baud_r  <= 16'd0;
      guard_r <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      te_r    <= 1'b0;
    end else begin
      baud_r <= (state_r == ST_IDLE || tick_s) ? 16'd0 : baud_r + 16'd1;
      if (pop_s) begin
        state_r <= ST_START;
        shift_r <= head_s;
        tx_r    <= 1'b0;
        te_r    <= 1'b1;
        guard_r <= 16'd0;
        bit_r   <= 3'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            tx_r <= 1'b1;
            te_r <= 1'b0;
            if (!empty_s) begin
              state_r <= ST_PRE;
              te_r    <= 1'b1;
              guard_r <= 16'd0;
            end
          end
          ST_PRE: begin
            if (tick_s) guard_r <= guard_r + 16'd1;
          end
          ST_START: begin
            if (tick_s) begin
              state_r <= ST_DATA;
              tx_r    <= shift_r[0];
              bit_r   <= 3'd0;
            end
          end
          ST_DATA: begin
            if (tick_s) begin
              if (bit_r == 3'd7) begin
                state_r <= ST_STOP;
                tx_r    <= 1'b1;
              end else begin
                bit_r   <= bit_r + 3'd1;
                shift_r <= {1'b0, shift_r[7:1]};
                tx_r    <= shift_r[1];
              end
            end
          end
          ST_STOP, ST_HOLD: begin
            // Reaching here at a tick means the FIFO is empty; stay on the line while the frame is open.
            if (tick_s && !(state_r == ST_HOLD && pk_frm)) begin
              if (state_r == ST_STOP && pk_frm) begin
                state_r <= ST_HOLD;
              end else if (GUARD_POST == 0) begin
                state_r <= ST_IDLE;
                te_r    <= 1'b0;
              end else begin
                state_r <= ST_POST;
                guard_r <= 16'd0;
              end
            end
          end
          ST_POST: begin
            if (tick_s) begin
              if (guard_r == POST_LAST_C) begin
                state_r <= ST_IDLE;
                te_r    <= 1'b0;
              end else begin
                guard_r <= guard_r + 16'd1;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            tx_r    <= 1'b1;
            te_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx       = tx_r;
  assign te       = te_r;
  assign re       = te_r;
  assign busy     = (state_r != ST_IDLE) || !empty_s;
  assign fifo_cnt = cnt_r;
  assign ovf_cnt  = ovf_r;

endmodule

// File: tb/tb_pk_uart_tx.sv
// Bench for pk_uart_tx: directed byte stimulus feeds an expected-byte queue; a UART
// line monitor decodes every frame off tx and checks it against that queue.
module tb_pk_uart_tx;

  localparam int DEPTH = 4;
  localparam int BD    = 4;
  localparam int GPRE  = 2;
  localparam int GPOST = 1;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic [7:0] pk_data;
  logic       pk_vld;
  logic       pk_frm;
  logic       ovf_clr;
  logic       tx, te, re, busy;
  logic [2:0] fifo_cnt;
  logic [7:0] ovf_cnt;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  int         frames_done = 0;
  int         cyc = 0;

  pk_uart_tx #(.DEPTH(DEPTH), .BAUD_DIV(BD), .GUARD_PRE(GPRE), .GUARD_POST(GPOST)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pk_data(pk_data), .pk_vld(pk_vld), .pk_frm(pk_frm),
    .tx(tx), .te(te), .re(re), .busy(busy), .fifo_cnt(fifo_cnt), .ovf_cnt(ovf_cnt),
    .ovf_clr(ovf_clr)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    pk_data = b;
    pk_vld  = 1'b1;
    @(posedge clk_sys); #1;
    pk_vld  = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 3000 && frames_done < target; i++) begin
      @(negedge clk_sys); #1;
    end
    chk("wait_frames", frames_done, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && !(busy === 1'b0 && te === 1'b0); i++) begin
      @(negedge clk_sys); #1;
    end
    chk("wait_idle", 32'({busy, te}), 32'd0);
  endtask

  // Counts the negedges on which te is high, from its rise to its fall.
  task automatic measure_te_run(output int run);
    run = 0;
    for (int i = 0; i < 200 && te !== 1'b1; i++) @(negedge clk_sys);
    if (te === 1'b1) begin
      while (te === 1'b1 && run < 3000) begin
        run++;
        @(negedge clk_sys);
      end
    end else begin
      run = -1;
    end
  endtask

  // Line monitor: every cycle of every bit must hold the bit value, with te/re high throughout.
  int         mon_cnt;
  int         mon_bad;
  logic       mon_busy = 1'b0;
  logic [9:0] mon_bits;
  logic [7:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk_sys);
      if (rst_n !== 1'b1) begin
        mon_busy = 1'b0;
      end else begin
        if (!mon_busy && tx === 1'b0) begin
          mon_busy = 1'b1;
          mon_cnt  = 0;
          mon_bad  = 0;
          mon_bits = 10'd0;
          start_cyc.push_back(cyc);
        end else if (mon_busy) begin
          mon_cnt++;
        end
        if (mon_busy) begin
          if (mon_cnt % BD == 0) mon_bits[mon_cnt / BD] = tx;
          else if (tx !== mon_bits[mon_cnt / BD]) mon_bad++;
          if (te !== 1'b1 || re !== 1'b1) mon_bad++;
          if (mon_cnt == 10 * BD - 1) begin
            mon_busy = 1'b0;
            frames_done++;
            chk("frame_start_stop", 32'({mon_bits[9], mon_bits[0]}), 32'd2);
            chk("frame_width_te", mon_bad, 0);
            if (exp_q.size() == 0) begin
              chk("frame_unexpected", 32'(mon_bits[8:1]), 32'hFFFF_FFFF);
            end else begin
              mon_exp = exp_q.pop_front();
              chk("frame_data", 32'(mon_bits[8:1]), 32'(mon_exp));
            end
          end
        end
      end
    end
  end

  int run;
  int idx;
  int f0;
  int cnt;

  initial begin
    rst_n = 1'b0; pk_vld = 1'b0; pk_data = 8'hC3; pk_frm = 1'b0; ovf_clr = 1'b0;

    // Reset hold with pk_vld toggling
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_sys); #1;
      pk_vld  = ~pk_vld;
      pk_data = ~pk_data;
      @(negedge clk_sys);
      chk("reset_hold", 32'({tx, te, re, busy, ovf_cnt, fifo_cnt}), 32'({4'b1000, 8'h00, 3'd0}));
    end
    @(posedge clk_sys); #1;
    rst_n = 1'b1; pk_vld = 1'b0;

    // Single byte 0xA5 inside a pk_frm pulse
    @(posedge clk_sys); #1; pk_frm = 1'b1;
    @(posedge clk_sys); #1;
    exp_q.push_back(8'hA5);
    send(8'hA5);
    pk_frm = 1'b0;
    @(negedge clk_sys);
    chk("lat_one_cycle", 32'({te, busy, fifo_cnt}), 32'({1'b0, 1'b1, 3'd1}));
    @(negedge clk_sys);
    chk("lat_te_rise", 32'({te, re, tx}), 32'd7);
    cnt = 1;
    repeat (7) begin
      @(negedge clk_sys);
      if (tx === 1'b1 && te === 1'b1) cnt++;
    end
    chk("pre_guard_len", cnt, 8);
    @(negedge clk_sys);
    chk("start_bit_time", 32'(tx), 32'd0);
    repeat (39) @(negedge clk_sys);
    cnt = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (tx === 1'b1 && te === 1'b1) cnt++;
    end
    chk("post_guard_len", cnt, 4);
    @(negedge clk_sys);
    chk("te_fall_idle", 32'({te, re, busy, fifo_cnt}), 32'd0);

    // Back-to-back 0x00, 0xFF, 0x55 with pk_frm low
    idx = start_cyc.size();
    f0  = frames_done;
    fork
      measure_te_run(run);
      begin
        @(posedge clk_sys); #1;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        send(8'h00); send(8'hFF); send(8'h55);
      end
    join
    chk("b2b_te_run", run, 132);
    wait_frames(f0 + 3);
    chk("b2b_gap1", start_cyc[idx + 1] - start_cyc[idx], 40);
    chk("b2b_gap2", start_cyc[idx + 2] - start_cyc[idx + 1], 40);
    wait_idle();

    // HOLD: second byte 100 cycles after the first stop bit, pk_frm high
    idx = start_cyc.size();
    f0  = frames_done;
    pk_frm = 1'b1;
    fork
      measure_te_run(run);
      begin
        @(posedge clk_sys); #1;
        exp_q.push_back(8'h3C);
        send(8'h3C);
        wait_frames(f0 + 1);
        repeat (100) @(posedge clk_sys);
        #1;
        exp_q.push_back(8'hC3);
        send(8'hC3);
        pk_frm = 1'b0;
      end
    join
    chk("hold_te_run", run, 196);
    wait_frames(f0 + 2);
    chk("hold_start_gap", start_cyc[idx + 1] - start_cyc[idx], 144);
    wait_idle();

    // Overflow: six bytes into a four-deep FIFO, then clear racing a dropped write
    f0 = frames_done;
    @(posedge clk_sys); #1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    @(negedge clk_sys);
    chk("ovf_peak", 32'({fifo_cnt, ovf_cnt}), 32'({3'd4, 8'd2}));
    @(posedge clk_sys); #1;
    pk_data = 8'h77; pk_vld = 1'b1; ovf_clr = 1'b1;
    @(posedge clk_sys); #1;
    pk_vld = 1'b0; ovf_clr = 1'b0;
    @(negedge clk_sys);
    chk("ovf_clr_priority", 32'({fifo_cnt, ovf_cnt}), 32'({3'd4, 8'd0}));
    wait_frames(f0 + 4);
    wait_idle();
    chk("ovf_queue_drained", exp_q.size(), 0);

    // Mid-byte reset during data bit 3 of 0x96, with 0x5A still queued
    idx = start_cyc.size();
    f0  = frames_done;
    @(posedge clk_sys); #1;
    exp_q.push_back(8'h96); exp_q.push_back(8'h5A);
    send(8'h96); send(8'h5A);
    for (int i = 0; i < 100 && start_cyc.size() == idx; i++) begin
      @(negedge clk_sys); #1;
    end
    chk("rst_start_seen", start_cyc.size(), idx + 1);
    repeat (17) @(posedge clk_sys);
    #1; rst_n = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_mid_byte", 32'({tx, te, re, busy, fifo_cnt}), 32'({4'b1000, 3'd0}));
    exp_q.delete();
    @(posedge clk_sys); #1; rst_n = 1'b1;
    cnt = 0;
    repeat (200) begin
      @(negedge clk_sys);
      if (tx !== 1'b1 || te !== 1'b0 || fifo_cnt !== 3'd0) cnt++;
    end
    chk("rst_line_quiet", cnt, 0);
    chk("rst_no_frame", frames_done, f0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
